if_fetch: RTL and testbench
===========================

// Module: if_fetch
// PURPOSE
//   Instruction-fetch stage of the NJU-MIPS pipeline, directly upstream of if_id.
//   Owns the PC, issues word fetches to instruction memory over a req/gnt/rvalid handshake,
//   and buffers returned words in a 2-entry queue.
//   Presents {pc, inst} to if_id each cycle. Handles stall from the hazard unit and
//   PC redirect (branch/jump/exception flush) from later stages.
// PARAMETERS
//   RESET_PC  32'h0000_0000  first fetch address after reset
//   BUF_DEPTH 2              output queue entries (fixed at 2; other values unsupported)
// PORTS
//   clk          in   1   clock, all state on posedge
//   rst          in   1   asynchronous, active-low reset (rst==0 resets)
//   stall        in   1   downstream hold; if_id does not consume this cycle
//   flush        in   1   redirect valid; discards all fetched and in-flight words
//   new_pc       in   32  redirect target; bits[1:0] ignored (treated as 00)
//   imem_req     out  1   fetch request
//   imem_addr    out  32  fetch address, word aligned
//   imem_gnt     in   1   memory accepts request this cycle (req&gnt = handshake)
//   imem_rvalid  in   1   read data valid; exactly one per accepted request, >=1 cycle later
//   imem_rdata   in   32  instruction word
//   if_pc        out  32  PC of presented instruction
//   if_inst      out  32  presented instruction
//   if_valid     out  1   queue head valid
// BEHAVIOUR
//   Reset (async assert, sync release):
//   - pc=RESET_PC, queue empty, no outstanding request.
//   - imem_req=0, imem_addr=RESET_PC, if_pc=if_inst=`ZEROWORD, if_valid=0.
//   FSM states: IDLE, REQ, WAIT, DROP.
//   - IDLE -> REQ on the first clock after rst release.
//   - REQ: imem_req=1 iff (queue count + 0 outstanding) < 2; imem_addr=pc.
//     On req&gnt: req_pc<=pc, pc<=pc+4 (mod 2^32, 0xFFFFFFFC wraps to 0x0), -> WAIT.
//   - WAIT: imem_req=0. On rvalid: push {req_pc, rdata} into the queue, -> REQ.
//   - DROP: imem_req=0. On rvalid: discard the data, -> REQ.
//   - imem_req/imem_addr stay stable while gnt=0. A request is never withdrawn except by flush or reset.
//   - At most one request outstanding.
//   - Throughput: 1 instruction per 2 cycles with a 0-wait memory (gnt same cycle, rvalid next cycle).
//   Queue:
//   - Pop at posedge when stall=0 and if_valid=1. Push on WAIT&rvalid.
//   - Push and pop in the same cycle are legal; count stays unchanged.
//   - Request admission guarantees no push ever hits a full queue.
//   - Outputs are taken from the queue head. When the queue is empty: if_valid=0 and if_pc=if_inst=`ZEROWORD (nop bubble).
//   - Latency: rvalid at cycle t gives if_valid=1 at t+1 (head registered).
//   Flush (priority over stall, rvalid and gnt):
//   - pc<=new_pc&~3 and the queue is cleared (if_valid=0 next cycle).
//   - From WAIT, or from REQ with gnt in the same cycle: next state DROP.
//   - From WAIT with rvalid in the same cycle: that data is discarded, next state REQ.
//   - From REQ without gnt, or from IDLE: next state REQ.
//   - From DROP: remain in DROP until the pending rvalid arrives.
//   - Next imem_addr is new_pc. The first valid if_pc after a flush is new_pc.
//   Stall: no pop; the head is held stable on if_pc/if_inst. Fetch continues until the queue is full.
//   Reset mid-transaction: the outstanding request is abandoned. The memory is reset on the same rst.
// STRUCTURE
//   - macro.v additions: `FETCH_IDLE/REQ/WAIT/DROP 2-bit encodings and `PCINC (32'd4).
//   - Reused from macro.v: `INSTADDRBUS, `INSTBUS, `ZEROWORD.
//   - Sub-module if_buf: 2-entry FIFO of {pc[31:0], inst[31:0]} with push, pop, clr, count, and head outputs.
//   - PC/FSM logic lives in if_fetch.
// TESTING
//   - Reset: hold rst=0 for 3 cycles during WAIT -> req=0, if_valid=0, outputs 0. After release -> next cycle imem_req=1, addr=0x0.
//   - Straight line, 0-wait memory returning addr^0xA5A5_0000 -> if_pc sequence 0,4,8,12 with matching if_inst, if_valid on alternate cycles.
//   - gnt held low 3 cycles -> imem_req=1 and imem_addr=0x8 stable throughout. pc advances only after gnt.
//   - stall=1 for 8 cycles -> queue holds 0x0,0x4; imem_req drops; if_pc stays 0x0. Release -> 0x0 then 0x4 emitted, then 0x8; no loss or duplication.
//   - flush with new_pc=0x103 while in WAIT for 0x20 -> late rvalid dropped, next imem_addr=0x100, first valid if_pc=0x100.
//   - flush+stall+rvalid in the same cycle, new_pc=0xFFFFFFFC -> if_valid=0 next cycle; fetches 0xFFFFFFFC then wraps to 0x0.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;

  typedef enum logic [1:0] {
    FetchIdle = 2'd0,
    FetchReq  = 2'd1,
    FetchWait = 2'd2,
    FetchDrop = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PcInc    = 32'd4;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // Redirect targets may be unaligned; the low two bits are forced to zero.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_buf.sv
// Two-entry FIFO of {pc, inst} pairs feeding if_id; head is registered.
module if_buf
  import if_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        clr,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_inst,
  output logic [1:0]  count,
  output logic        head_valid,
  output logic [31:0] head_pc,
  output logic [31:0] head_inst
);

  logic [31:0] pc_q   [2];
  logic [31:0] inst_q [2];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  count_q;
  logic        do_push;
  logic        do_pop;

  assign do_push = push && (count_q != 2'd2);
  assign do_pop  = pop && (count_q != 2'd0);

  // Storage, pointers and occupancy; clr drops everything in one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        pc_q[i]   <= ZeroWord;
        inst_q[i] <= ZeroWord;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (clr) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        pc_q[wr_ptr_q]   <= push_pc;
        inst_q[wr_ptr_q] <= push_inst;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(do_push) - 2'(do_pop);
    end
  end

  // Empty queue presents a zero bubble.
  always_comb begin
    count      = count_q;
    head_valid = (count_q != 2'd0);
    head_pc    = head_valid ? pc_q[rd_ptr_q] : ZeroWord;
    head_inst  = head_valid ? inst_q[rd_ptr_q] : ZeroWord;
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, imem req/gnt/rvalid handshake, 2-entry output queue.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  localparam logic [1:0] Depth = 2'(BUF_DEPTH);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic [1:0]   buf_count;
  logic         admit;
  logic         push;
  logic         pop;

  // Only one request is ever outstanding, so the queue count alone bounds admission.
  assign admit     = (buf_count < Depth);
  assign imem_addr = pc_q;
  assign pop       = !stall && if_valid;

  // State, PC and the address of the in-flight request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= FetchIdle;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  // Next-state, PC advance and request generation; flush overrides everything.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    imem_req = 1'b0;
    push     = 1'b0;
    unique case (state_q)
      FetchIdle: state_d = FetchReq;
      FetchReq: begin
        imem_req = admit;
        if (admit && imem_gnt) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + PcInc;
          state_d  = FetchWait;
        end
      end
      FetchWait: begin
        if (imem_rvalid) begin
          push    = 1'b1;
          state_d = FetchReq;
        end
      end
      FetchDrop: begin
        if (imem_rvalid) state_d = FetchReq;
      end
      default: state_d = FetchIdle;
    endcase
    if (flush) begin
      pc_d = word_align(new_pc);
      push = 1'b0;
      // A granted or pending request still owes one rvalid that must be swallowed.
      unique case (state_q)
        FetchWait: state_d = imem_rvalid ? FetchReq : FetchDrop;
        FetchReq:  state_d = (admit && imem_gnt) ? FetchDrop : FetchReq;
        FetchDrop: state_d = imem_rvalid ? FetchReq : FetchDrop;
        default:   state_d = FetchReq;
      endcase
    end
  end

  if_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .clr        (flush),
    .push_pc    (req_pc_q),
    .push_inst  (imem_rdata),
    .count      (buf_count),
    .head_valid (if_valid),
    .head_pc    (if_pc),
    .head_inst  (if_inst)
  );

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a behavioural instruction memory.
module tb_if_fetch;

  localparam logic [31:0] Key = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush;
  logic [31:0] new_pc;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] if_pc, if_inst;
  logic        if_valid;

  // Memory model controls (written by the test, read by the model at negedge).
  logic        gnt_en;
  int          lat_extra;
  logic        pend;
  logic [31:0] pend_addr;
  int          cnt;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic        stall;
    logic        gnt_en;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } vec_t;

  vec_t vecs[21];

  if_fetch #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .new_pc      (new_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .if_valid    (if_valid)
  );

  always #5 clk = ~clk;

  // Instruction memory: grants when enabled, returns addr^Key 1+lat_extra cycles later.
  initial begin
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    pend = 1'b0; pend_addr = 32'h0; cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pend = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      end else begin
        imem_rvalid = 1'b0;
        if (pend) begin
          if (cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend_addr ^ Key;
            pend        = 1'b0;
          end else begin
            cnt = cnt - 1;
          end
        end
        if (imem_req && gnt_en && !pend) begin
          imem_gnt  = 1'b1;
          pend      = 1'b1;
          pend_addr = imem_addr;
          cnt       = lat_extra;
        end else begin
          imem_gnt = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic er, input logic ea_en,
                            input logic [31:0] ea, input logic ev, input logic [31:0] ep,
                            input logic [31:0] ei);
    chk({tag, " req"}, 32'(imem_req), 32'(er));
    if (ea_en) chk({tag, " addr"}, imem_addr, ea);
    chk({tag, " valid"}, 32'(if_valid), 32'(ev));
    chk({tag, " pc"}, if_pc, ep);
    chk({tag, " inst"}, if_inst, ei);
  endtask

  function automatic vec_t mk(input logic s, input logic g, input logic r,
                              input logic [31:0] a, input logic v, input logic [31:0] p,
                              input logic [31:0] i);
    vec_t t;
    t.stall = s; t.gnt_en = g; t.req = r; t.addr = a; t.valid = v; t.pc = p; t.inst = i;
    return t;
  endfunction

  initial begin
    // Straight line, gnt held low three cycles at 0x8, then eight cycles of stall.
    vecs[0]  = mk(0, 1, 1, 32'h00, 0, 32'h00, 32'h0);
    vecs[1]  = mk(0, 1, 0, 32'h00, 0, 32'h00, 32'h0);
    vecs[2]  = mk(0, 1, 1, 32'h04, 1, 32'h00, 32'hA5A5_0000);
    vecs[3]  = mk(0, 1, 0, 32'h00, 0, 32'h00, 32'h0);
    vecs[4]  = mk(0, 1, 1, 32'h08, 1, 32'h04, 32'hA5A5_0004);
    vecs[5]  = mk(0, 0, 1, 32'h08, 0, 32'h00, 32'h0);
    vecs[6]  = mk(0, 0, 1, 32'h08, 0, 32'h00, 32'h0);
    vecs[7]  = mk(0, 0, 1, 32'h08, 0, 32'h00, 32'h0);
    vecs[8]  = mk(0, 1, 0, 32'h00, 0, 32'h00, 32'h0);
    vecs[9]  = mk(0, 1, 1, 32'h0C, 1, 32'h08, 32'hA5A5_0008);
    for (int k = 10; k < 18; k++) begin
      vecs[k] = mk(1, 1, 0, 32'h00, 1, 32'h08, 32'hA5A5_0008);
    end
    vecs[18] = mk(0, 1, 1, 32'h10, 1, 32'h0C, 32'hA5A5_000C);
    vecs[19] = mk(0, 1, 0, 32'h00, 0, 32'h00, 32'h0);
    vecs[20] = mk(0, 1, 1, 32'h14, 1, 32'h10, 32'hA5A5_0010);

    rst = 1'b0; stall = 1'b0; flush = 1'b0; new_pc = 32'h0;
    gnt_en = 1'b1; lat_extra = 0;
    repeat (2) step();
    expect_out("reset", 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;

    for (int k = 0; k < 21; k++) begin
      stall  = vecs[k].stall;
      gnt_en = vecs[k].gnt_en;
      step();
      expect_out($sformatf("vec%0d", k), vecs[k].req, vecs[k].req, vecs[k].addr,
                 vecs[k].valid, vecs[k].pc, vecs[k].inst);
    end
    stall = 1'b0; gnt_en = 1'b1;

    // Reset asserted while a fetch of 0x14 is outstanding.
    step();
    chk("pre-reset wait req", 32'(imem_req), 32'h0);
    rst = 1'b0;
    #1;
    expect_out("rst assert", 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      expect_out($sformatf("rst hold%0d", k), 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    end
    rst = 1'b1;
    step();
    expect_out("rst release", 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

    // Flush from REQ without grant redirects to 0x20.
    gnt_en = 1'b0; flush = 1'b1; new_pc = 32'h20;
    step();
    expect_out("flush req", 1'b1, 1'b1, 32'h20, 1'b0, 32'h0, 32'h0);
    flush = 1'b0; gnt_en = 1'b1; lat_extra = 2;
    step();
    expect_out("wait 0x20", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    // Flush to unaligned 0x103 while 0x20 is still in flight.
    flush = 1'b1; new_pc = 32'h103;
    step();
    expect_out("flush wait", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    flush = 1'b0;
    step();
    expect_out("drop hold", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    step();
    expect_out("drop done", 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0);
    lat_extra = 0;
    step();
    expect_out("fetch 0x100", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    step();
    expect_out("emit 0x100", 1'b1, 1'b1, 32'h104, 1'b1, 32'h100, 32'hA5A5_0100);

    // Flush, stall and rvalid together; redirect to the last word, then wrap.
    stall = 1'b1;
    step();
    expect_out("stall wait", 1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 32'hA5A5_0100);
    flush = 1'b1; new_pc = 32'hFFFF_FFFC;
    step();
    expect_out("flush+rvalid", 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
    flush = 1'b0; stall = 1'b0;
    step();
    expect_out("fetch top", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    step();
    expect_out("emit top", 1'b1, 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h5A5A_FFFC);
    step();
    expect_out("fetch wrap", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    step();
    expect_out("emit wrap", 1'b1, 1'b1, 32'h4, 1'b1, 32'h0, 32'hA5A5_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
